sdr_16_rd_capture: RTL and testbench

- Read-data return path for the 16-bit SDR SDRAM controller.
- Sits directly downstream of the SDR command FSM.
- Watches the FSM's per-READ pulse, counts CAS latency plus I/O register delay, and captures the two 16-bit beats of each burst-length-2 read from the DQ pins.
- Packs each pair into one 32-bit word (first beat in the upper half) and writes it into the ingress FIFO toward the Wishbone side.

---
 rtl/sdr_16_rd_capture.sv | 95 +++++++++
 tb/tb_sdr_16_rd_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sdr_16_rd_capture.sv
// rtl/sdr_16_rd_capture.sv - SDR SDRAM burst-length-2 read capture, packs two 16-bit beats per 32-bit FIFO word
// Optional sticky overflow flag is built only when SDR16_RD_OVF_EN is defined.
module sdr_16_rd_capture #(
  parameter int cl     = 2,
  parameter int in_reg = 1
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst_n,
  input  logic        cmd_read,
  input  logic [15:0] dq_i,
  input  logic        fifo_full,
  input  logic        ovf_clr,
  output logic [31:0] data_o,
  output logic        data_we_o,
  output logic        rd_busy_o,
  output logic        ovf_o
);

  localparam int L = cl + in_reg;

  // vld_q[k] high means an accepted READ is k+1 cycles old; bit L-1 marks beat0, bit L marks beat1.
  logic [L:0]  vld_q;
  logic        accept;
  logic [15:0] hold_q;
  logic [2:0]  pend_q;
  logic [2:0]  pend_d;

  // A pulse right after an accepted READ cannot be a real command and is dropped.
  assign accept = cmd_read & ~vld_q[0];

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[L-1:0], accept};
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      hold_q <= '0;
    end else if (vld_q[L-1]) begin
      hold_q <= dq_i;
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      data_o    <= '0;
      data_we_o <= 1'b0;
    end else begin
      data_we_o <= vld_q[L];
      if (vld_q[L]) begin
        data_o <= {hold_q, dq_i};
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (accept && !data_we_o) begin
      pend_d = pend_q + 3'd1;
    end else if (!accept && data_we_o) begin
      pend_d = pend_q - 3'd1;
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      pend_q    <= '0;
      rd_busy_o <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      rd_busy_o <= (pend_d != 3'd0);
    end
  end

`ifdef SDR16_RD_OVF_EN
  // Set has priority over clear so a drop coinciding with a clear is not lost.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      ovf_o <= 1'b0;
    end else if (data_we_o && fifo_full) begin
      ovf_o <= 1'b1;
    end else if (ovf_clr) begin
      ovf_o <= 1'b0;
    end
  end
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = fifo_full ^ ovf_clr;
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// tb/tb_sdr_16_rd_capture.sv - self-checking bench for sdr_16_rd_capture across three latency configurations
module tb_sdr_16_rd_capture;

  localparam int NI   = 3;
  localparam int MAXC = 4096;
`ifdef SDR16_RD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        sdram_clk   = 1'b0;
  logic        sdram_rst_n = 1'b0;
  logic        cmd_read    = 1'b0;
  logic [15:0] dq_i        = '0;
  logic        fifo_full   = 1'b0;
  logic        ovf_clr     = 1'b0;

  logic [31:0] data_o    [NI];
  logic        data_we_o [NI];
  logic        rd_busy_o [NI];
  logic        ovf_o     [NI];

  sdr_16_rd_capture #(.cl(2), .in_reg(1)) u_a (
    .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .cmd_read(cmd_read), .dq_i(dq_i),
    .fifo_full(fifo_full), .ovf_clr(ovf_clr), .data_o(data_o[0]), .data_we_o(data_we_o[0]),
    .rd_busy_o(rd_busy_o[0]), .ovf_o(ovf_o[0]));

  sdr_16_rd_capture #(.cl(3), .in_reg(0)) u_b (
    .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .cmd_read(cmd_read), .dq_i(dq_i),
    .fifo_full(fifo_full), .ovf_clr(ovf_clr), .data_o(data_o[1]), .data_we_o(data_we_o[1]),
    .rd_busy_o(rd_busy_o[1]), .ovf_o(ovf_o[1]));

  sdr_16_rd_capture #(.cl(3), .in_reg(1)) u_c (
    .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .cmd_read(cmd_read), .dq_i(dq_i),
    .fifo_full(fifo_full), .ovf_clr(ovf_clr), .data_o(data_o[2]), .data_we_o(data_we_o[2]),
    .rd_busy_o(rd_busy_o[2]), .ovf_o(ovf_o[2]));

  always #5 sdram_clk = ~sdram_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_rst = 0;
  int          t0 = 0;
  int          lat [NI] = '{3, 3, 4};
  bit          h_acc [MAXC];
  logic [15:0] h_dq  [MAXC];
  logic [31:0] m_data [NI];
  bit          m_ovf [NI];
  bit          m_we_prev [NI];
  bit          full_prev = 1'b0;
  bit          clr_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a READ accepted in cycle n is written in cycle n+L+2 as {dq(n+L), dq(n+L+1)}
  // and counts as pending in cycles n+1 .. n+L+2.
  task automatic model_and_check();
    bit rst_now;
    rst_now = !sdram_rst_n;
    h_dq[cyc] = dq_i;
    if (rst_now) begin
      last_rst   = cyc;
      h_acc[cyc] = 1'b0;
    end else begin
      h_acc[cyc] = cmd_read && !h_acc[cyc-1];
    end
    for (int i = 0; i < NI; i++) begin
      int  n;
      int  lo;
      int  cnt;
      bit  we;
      n   = cyc - lat[i] - 2;
      we  = !rst_now && (n > last_rst) && h_acc[n];
      lo  = (last_rst + 1 > n) ? last_rst + 1 : n;
      cnt = 0;
      for (int k = lo; k < cyc; k++) cnt += int'(h_acc[k]);
      if (rst_now) begin
        m_data[i] = '0;
        m_ovf[i]  = 1'b0;
      end else begin
        if (we) m_data[i] = {h_dq[cyc-2], h_dq[cyc-1]};
        m_ovf[i] = OVF_EN && ((m_we_prev[i] && full_prev) || (m_ovf[i] && !clr_prev));
      end
      m_we_prev[i] = we;
      chk($sformatf("u%0d.data_o c%0d", i, cyc), data_o[i], m_data[i]);
      chk($sformatf("u%0d.data_we_o c%0d", i, cyc), 32'(data_we_o[i]), 32'(we));
      chk($sformatf("u%0d.rd_busy_o c%0d", i, cyc), 32'(rd_busy_o[i]), 32'(cnt != 0));
      chk($sformatf("u%0d.ovf_o c%0d", i, cyc), 32'(ovf_o[i]), 32'(m_ovf[i]));
    end
    full_prev = fifo_full && !rst_now;
    clr_prev  = ovf_clr;
  endtask

  task automatic tick(input bit rn, input bit cmd, input logic [15:0] dq, input bit full, input bit clr);
    @(posedge sdram_clk);
    cyc++;
    #1;
    sdram_rst_n = rn;
    cmd_read    = cmd;
    dq_i        = dq;
    fifo_full   = full;
    ovf_clr     = clr;
    @(negedge sdram_clk);
    model_and_check();
  endtask

  task automatic start_seg();
    tick(1'b0, 1'b0, 16'($urandom), 1'b0, 1'b0);
    t0 = cyc;
  endtask

  initial begin
    int          rel;
    int          nwe;
    logic [31:0] saved;

    // Single read, cl=2/in_reg=1 timing and busy window.
    start_seg();
    for (int r = 1; r <= 20; r++) begin
      tick(1'b1, r == 10, (r == 13) ? 16'hA5A5 : (r == 14) ? 16'h3C3C : 16'($urandom), 1'b0, 1'b0);
      rel = cyc - t0;
      if (rel == 11) chk("tp1_busy_c11", 32'(rd_busy_o[0]), 32'd1);
      if (rel == 15) begin
        chk("tp1_we_c15", 32'(data_we_o[0]), 32'd1);
        chk("tp1_data_c15", data_o[0], 32'hA5A53C3C);
      end
      if (rel == 16) chk("tp1_busy_c16", 32'(rd_busy_o[0]), 32'd0);
    end

    // Back-to-back reads at spacing 2 stream without gaps.
    start_seg();
    for (int r = 1; r <= 24; r++) begin
      tick(1'b1, r == 10 || r == 12 || r == 14,
           (r >= 13 && r <= 18) ? 16'(r - 12) : 16'($urandom), 1'b0, 1'b0);
      rel = cyc - t0;
      if (rel == 15) chk("tp2_w1", data_o[1], 32'h00010002);
      if (rel == 17) chk("tp2_w2", data_o[1], 32'h00030004);
      if (rel == 19) begin
        chk("tp2_w3", data_o[1], 32'h00050006);
        chk("tp2_we3", 32'(data_we_o[1]), 32'd1);
      end
    end

    // Adjacent pulses: second one ignored.
    start_seg();
    nwe = 0;
    for (int r = 1; r <= 22; r++) begin
      tick(1'b1, r == 10 || r == 11, 16'($urandom), 1'b0, 1'b0);
      if (data_we_o[0]) nwe++;
    end
    chk("tp3_one_word", 32'(nwe), 32'd1);
    chk("tp3_idle_busy", 32'(rd_busy_o[0]), 32'd0);

    // Reset mid-burst discards the read.
    start_seg();
    nwe = 0;
    for (int r = 1; r <= 22; r++) begin
      tick(r != 13, r == 10, 16'($urandom), 1'b0, 1'b0);
      if (data_we_o[0] || data_we_o[1] || data_we_o[2]) nwe++;
    end
    chk("tp4_no_write", 32'(nwe), 32'd0);
    chk("tp4_data_zero", data_o[0], 32'd0);

    // Overflow flag: write while full, then clear.
    start_seg();
    for (int r = 1; r <= 24; r++) begin
      tick(1'b1, r == 10, 16'($urandom), r == 15, r == 20);
      rel = cyc - t0;
      if (rel == 17) chk("tp5_ovf_held", 32'(ovf_o[0]), 32'(OVF_EN));
      if (rel == 21) chk("tp5_ovf_clr", 32'(ovf_o[0]), 32'd0);
    end

    // Idle bus with toggling data.
    saved = data_o[2];
    nwe = 0;
    for (int r = 0; r < 100; r++) begin
      tick(1'b1, 1'b0, 16'($urandom), 1'($urandom), 1'b0);
      if (data_we_o[2] || rd_busy_o[2]) nwe++;
    end
    chk("tp6_idle_activity", 32'(nwe), 32'd0);
    chk("tp6_data_held", data_o[2], saved);

    // Random traffic with occasional resets, full and clear.
    for (int r = 0; r < 500; r++) begin
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0, 16'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
